// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: bus width, blank pattern and hex glyphs (bit6=g..bit0=a, 1=lit).
// Used by the upstream decoder and the scan driver alike.
package seg_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    logic [SEG_W-1:0] g;
    g = SEG_BLANK;
    case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Digit-slot timer: free-running 0..REFRESH_DIV-1 counter, combinational wrap pulse and blank flag.
// No backpressure; runs every cycle from reset.
module slot_timer
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic cnt_wrap,
  output logic in_blank
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
    $error("slot_timer: BLANK_CYCLES must be smaller than REFRESH_DIV");
  end

  logic [CNT_W-1:0] cnt;

  assign cnt_wrap = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign in_blank = (cnt < CNT_W'(BLANK_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_wrap ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with per-slot blanking and frame-boundary pattern swap.
// All outputs registered (1-cycle latency); no backpressure, load is a fire-and-forget strobe.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic                        load,
  output logic [SEG_W-1:0]            seg,
  output logic                        dp,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic cnt_wrap;
  logic in_blank;

  slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_slot_timer (
    .clk     (clk),
    .rst     (rst),
    .cnt_wrap(cnt_wrap),
    .in_blank(in_blank)
  );

  logic [IDX_W-1:0]      idx;
  logic [SEG_W-1:0]      shadow_seg [NUM_DIGITS];
  logic [SEG_W-1:0]      active_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [NUM_DIGITS-1:0] active_dp;
  logic                  pending;
  logic                  boundary;

  assign boundary = cnt_wrap && (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           idx <= '0;
    else if (cnt_wrap) idx <= boundary ? '0 : idx + 1'b1;
  end

  // active copies the pre-load shadow when load and boundary coincide; the new
  // data stays pending for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        shadow_seg[d] <= SEG_BLANK;
        active_seg[d] <= SEG_BLANK;
      end
      shadow_dp <= '0;
      active_dp <= '0;
      pending   <= 1'b0;
    end else begin
      if (boundary && pending) begin
        for (int d = 0; d < NUM_DIGITS; d++) active_seg[d] <= shadow_seg[d];
        active_dp <= shadow_dp;
      end
      if (load) begin
        for (int d = 0; d < NUM_DIGITS; d++) shadow_seg[d] <= seg_in[SEG_W*d +: SEG_W];
        shadow_dp <= dp_in;
      end
      if (load)          pending <= 1'b1;
      else if (boundary) pending <= 1'b0;
    end
  end

  logic [SEG_W-1:0]      seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  always_comb begin
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b0;
    an_nxt  = '0;
    if (!in_blank && digit_en[idx]) begin
      an_nxt[idx] = 1'b1;
      seg_nxt     = active_seg[idx];
      dp_nxt      = active_dp[idx];
    end
  end

  // Polarity is applied only here; everything upstream is 1=lit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= {SEG_W{ACTIVE_LOW}};
      dp         <= ACTIVE_LOW;
      an         <= {NUM_DIGITS{ACTIVE_LOW}};
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt ^ {SEG_W{ACTIVE_LOW}};
      dp         <= dp_nxt ^ ACTIVE_LOW;
      an         <= an_nxt ^ {NUM_DIGITS{ACTIVE_LOW}};
      frame_done <= boundary;
    end
  end

endmodule
